can_bit_destuffer: RTL and testbench
====================================

// Module: can_bit_destuffer
// PURPOSE
//  Receive-side stage directly downstream of bit_timing_module. Samples the rx level on each sample_point pulse.
//  Removes CAN stuff bits after STUFF_LEN equal bits and flags stuff errors. Accumulates CRC-15 over the de-stuffed
//  bits. Feeds one de-stuffed bit per nominal bit time to the frame decoder.
// PARAMETERS
//  STUFF_LEN  5        equal consecutive bits that force a stuff bit
//  CRC_W      15       CRC register width
//  CRC_POLY   15'h4599 CAN CRC-15 generator polynomial (x^15 term implicit)
// PORTS
//  clk          in   1       system clock, all state on posedge
//  rst_n        in   1       asynchronous reset, active-low
//  rx           in   1       synchronized bus level (0 = dominant)
//  sample_point in   1       1-cycle pulse from bit_timing_module; rx is sampled in this cycle
//  destuff_en   in   1       1 = inside stuffed region (SOF..CRC); 0 = pass-through
//  crc_en       in   1       1 = include output data bits in CRC
//  crc_clr      in   1       synchronous CRC clear to 0
//  bit_valid    out  1       1-cycle pulse: bit_data holds a de-stuffed bit
//  bit_data     out  1       de-stuffed bit value
//  stuff_bit    out  1       1-cycle pulse: a stuff bit was removed
//  stuff_err    out  1       level: stuff rule violated, held in ERROR state
//  crc_out      out  CRC_W   current CRC register
//  crc_zero     out  1       combinational (crc_out == 0)
// BEHAVIOUR
//  Reset (rst_n=0, any time, incl. mid-frame): state=IDLE, run_cnt=0, last_bit=1, all outputs 0, crc_out=0.
//  Latency: outputs register in the cycle after sample_point. No outputs change without sample_point,
//   except stuff_err clearing and CRC clear.
//  destuff_en and crc_en are sampled in the same cycle as sample_point.
//  States:
//   IDLE: on sample_point, bit_valid=1 and bit_data=rx. If destuff_en=1 -> COUNT with run_cnt=1, last_bit=rx.
//   COUNT: on sample_point, emit the bit. run_cnt = (rx==last_bit) ? run_cnt+1 : 1. last_bit=rx.
//    If the new run_cnt==STUFF_LEN -> EXPECT_STUFF.
//   EXPECT_STUFF: on sample_point:
//    - rx != last_bit: no bit_valid; stuff_bit=1; run_cnt=1; last_bit=rx (stuff bit starts the next run) -> COUNT.
//    - rx == last_bit: no bit_valid; stuff_err=1 -> ERROR.
//   ERROR: stuff_err held 1, sample_points ignored, CRC frozen. destuff_en=0 -> IDLE next cycle, stuff_err=0.
//  destuff_en=0 while in COUNT/EXPECT_STUFF -> IDLE next cycle. If this coincides with sample_point, the bit is
//   emitted as pass-through with no stuff check.
//  run_cnt: 3 bits, saturates by construction (never exceeds STUFF_LEN).
//  CRC update, in the same cycle bit_valid is registered, only when crc_en=1 and a data bit is emitted
//   (never for stuff bits):
//   nxt = bit ^ crc[14]; crc = {crc[13:0],1'b0} ^ (nxt ? CRC_POLY : 0).
//  crc_clr has priority over a simultaneous update. crc_clr does not affect de-stuff state.
//  bit_valid and stuff_bit are never high together. stuff_err never pulses together with bit_valid.
// TESTING
//  1. destuff_en=1, rx bits 0,0,0,0,0,1,0 -> bit_valid x5 (data 0), stuff_bit pulse on 6th, bit_valid data 0 on 7th.
//  2. destuff_en=1, six 0 bits -> 5 bit_valid, stuff_err=1 after 6th, later samples ignored;
//     destuff_en=0 -> stuff_err=0.
//  3. Bits 0,0,0,0,0,[1 stuff],1,1,1,1 -> next sample 0 removed as stuff (stuff bit counted in run); 9 data bits total.
//  4. crc_clr then crc_en=1, single data bit 1 -> crc_out=15'h4599. Random 40-bit payload matches software CRC-15;
//     payload+crc gives crc_zero=1.
//  5. destuff_en=0, eight 0 bits -> 8 bit_valid, no stuff_bit/stuff_err, state stays IDLE.
//  6. rst_n low mid-frame in EXPECT_STUFF -> all outputs 0 immediately; after release the first sample is IDLE pass-through.

Source files
------------

// File: rtl/can_bit_destuffer_if.sv
// Signal bundle between the bit-timing/frame-decoder side and the CAN bit de-stuffer.
// The master drives the sampled bus level and control strobes; the slave returns de-stuffed bits and CRC state.
interface can_bit_destuffer_if #(
    parameter int CRC_W = 15
);
    logic             rx;
    logic             sample_point;
    logic             destuff_en;
    logic             crc_en;
    logic             crc_clr;
    logic             bit_valid;
    logic             bit_data;
    logic             stuff_bit;
    logic             stuff_err;
    logic [CRC_W-1:0] crc_out;
    logic             crc_zero;

    modport master (
        output rx, sample_point, destuff_en, crc_en, crc_clr,
        input  bit_valid, bit_data, stuff_bit, stuff_err, crc_out, crc_zero
    );

    modport slave (
        input  rx, sample_point, destuff_en, crc_en, crc_clr,
        output bit_valid, bit_data, stuff_bit, stuff_err, crc_out, crc_zero
    );
endinterface

// File: rtl/can_bit_destuffer.sv
// CAN receive de-stuffer: removes stuff bits, flags stuff errors and accumulates CRC-15
// over the de-stuffed data bits, delivering one registered bit per sample_point.
module can_bit_destuffer #(
    parameter int               STUFF_LEN = 5,
    parameter int               CRC_W     = 15,
    parameter logic [CRC_W-1:0] CRC_POLY  = 15'h4599
) (
    input  logic                  clk,
    input  logic                  rst_n,
    can_bit_destuffer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        EXPECT_STUFF,
        ERROR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       run_cnt;
    logic [2:0]       run_next;
    logic [2:0]       run_inc;
    logic             last_bit;
    logic             last_next;
    logic             same_bit;
    logic             emit;
    logic             stuff_hit;
    logic             err_next;
    logic             crc_fb;
    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] crc_upd;

    assign same_bit = (bus.rx == last_bit);
    assign run_inc  = same_bit ? (run_cnt + 3'd1) : 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping destuff_en always wins and returns to pass-through on the next cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.sample_point && bus.destuff_en) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (!bus.destuff_en) begin
                    state_next = IDLE;
                end else if (bus.sample_point && (run_inc == 3'(STUFF_LEN))) begin
                    state_next = EXPECT_STUFF;
                end
            end
            EXPECT_STUFF: begin
                if (!bus.destuff_en) begin
                    state_next = IDLE;
                end else if (bus.sample_point) begin
                    state_next = same_bit ? ERROR : COUNT;
                end
            end
            ERROR: begin
                if (!bus.destuff_en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        emit      = 1'b0;
        stuff_hit = 1'b0;
        run_next  = run_cnt;
        last_next = last_bit;
        case (state)
            IDLE: begin
                run_next  = 3'd0;
                last_next = 1'b1;
                if (bus.sample_point) begin
                    emit = 1'b1;
                    if (bus.destuff_en) begin
                        run_next  = 3'd1;
                        last_next = bus.rx;
                    end
                end
            end
            COUNT: begin
                if (!bus.destuff_en) begin
                    emit      = bus.sample_point;
                    run_next  = 3'd0;
                    last_next = 1'b1;
                end else if (bus.sample_point) begin
                    emit      = 1'b1;
                    run_next  = run_inc;
                    last_next = bus.rx;
                end
            end
            EXPECT_STUFF: begin
                if (!bus.destuff_en) begin
                    emit      = bus.sample_point;
                    run_next  = 3'd0;
                    last_next = 1'b1;
                end else if (bus.sample_point && !same_bit) begin
                    // The stuff bit itself opens the next run of equal bits.
                    stuff_hit = 1'b1;
                    run_next  = 3'd1;
                    last_next = bus.rx;
                end
            end
            ERROR: begin
                if (!bus.destuff_en) begin
                    run_next  = 3'd0;
                    last_next = 1'b1;
                end
            end
            default: begin
                run_next  = 3'd0;
                last_next = 1'b1;
            end
        endcase
    end

    assign err_next = (state_next == ERROR);

    assign crc_fb  = bus.rx ^ crc_reg[CRC_W-1];
    assign crc_upd = {crc_reg[CRC_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt       <= 3'd0;
            last_bit      <= 1'b1;
            bus.bit_valid <= 1'b0;
            bus.bit_data  <= 1'b0;
            bus.stuff_bit <= 1'b0;
            bus.stuff_err <= 1'b0;
            crc_reg       <= '0;
        end else begin
            run_cnt       <= run_next;
            last_bit      <= last_next;
            bus.bit_valid <= emit;
            bus.bit_data  <= emit ? bus.rx : 1'b0;
            bus.stuff_bit <= stuff_hit;
            bus.stuff_err <= err_next;
            if (bus.crc_clr) begin
                crc_reg <= '0;
            end else if (emit && bus.crc_en) begin
                crc_reg <= crc_upd;
            end
        end
    end

    assign bus.crc_out  = crc_reg;
    assign bus.crc_zero = (crc_reg == '0);

    a_valid_stuff_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.bit_valid && bus.stuff_bit));
    a_valid_err_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.bit_valid && bus.stuff_err && $rose(bus.stuff_err)));
    a_run_bound : assert property (@(posedge clk) disable iff (!rst_n)
        run_cnt <= 3'(STUFF_LEN));

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Directed bench for can_bit_destuffer: table of single-sample vectors plus hand-written CRC and reset sequences.
module tb_can_bit_destuffer;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    can_bit_destuffer_if bus ();

    can_bit_destuffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   tag;
        logic sp;
        logic rx;
        logic den;
        logic ev;
        logic ed;
        logic es;
        logic ee;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic n;
        n = b ^ c[14];
        return {c[13:0], 1'b0} ^ (n ? 15'h4599 : 15'h0000);
    endfunction

    task automatic addVec(input int tag, input logic sp, input logic rx, input logic den,
                          input logic ev, input logic ed, input logic es, input logic ee);
        vec_t v;
        v.tag = tag; v.sp = sp; v.rx = rx; v.den = den;
        v.ev = ev; v.ed = ed; v.es = es; v.ee = ee;
        vecs.push_back(v);
    endtask

    // Drives one cycle (with or without a sample_point) and leaves the time just after the registering edge.
    task automatic applyStimulus(input logic sp, input logic rx, input logic den,
                                 input logic cen, input logic clr);
        bus.sample_point = sp;
        bus.rx           = rx;
        bus.destuff_en   = den;
        bus.crc_en       = cen;
        bus.crc_clr      = clr;
        @(posedge clk);
        #1;
        bus.sample_point = 1'b0;
        bus.crc_clr      = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic ed,
                               input logic es, input logic ee);
        logic [3:0] act;
        logic [3:0] exp;
        act = {bus.bit_valid, ev ? bus.bit_data : 1'b0, bus.stuff_bit, bus.stuff_err};
        exp = {ev, ev ? ed : 1'b0, es, ee};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got {valid,data,stuff,err}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 15'h%h expected 15'h%h", name, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [39:0] payload;
        logic [14:0] model;
        n_vec  = 0;
        n_fail = 0;

        // Test 1: five 0s, stuff 1, data 0, leave de-stuff region
        for (int i = 0; i < 5; i++) addVec(1, 1, 0, 1, 1, 0, 0, 0);
        addVec(1, 1, 1, 1, 0, 0, 1, 0);
        addVec(1, 1, 0, 1, 1, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 0);
        // Test 2: six 0s -> stuff error, samples ignored, cleared by destuff_en=0
        for (int i = 0; i < 5; i++) addVec(2, 1, 0, 1, 1, 0, 0, 0);
        addVec(2, 1, 0, 1, 0, 0, 0, 1);
        addVec(2, 1, 1, 1, 0, 0, 0, 1);
        addVec(2, 1, 0, 1, 0, 0, 0, 1);
        addVec(2, 0, 0, 0, 0, 0, 0, 0);
        // Test 3: stuff bit counts toward the following run
        for (int i = 0; i < 5; i++) addVec(3, 1, 0, 1, 1, 0, 0, 0);
        addVec(3, 1, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) addVec(3, 1, 1, 1, 1, 1, 0, 0);
        addVec(3, 1, 0, 1, 0, 0, 1, 0);
        addVec(3, 1, 0, 1, 1, 0, 0, 0);
        addVec(3, 0, 0, 0, 0, 0, 0, 0);
        // Test 4: pass-through never counts; then destuff_en drop coinciding with sample in EXPECT_STUFF
        for (int i = 0; i < 8; i++) addVec(4, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) addVec(4, 1, 0, 1, 1, 0, 0, 0);
        addVec(4, 1, 0, 0, 1, 0, 0, 0);
        addVec(4, 1, 0, 0, 1, 0, 0, 0);
        // Test 5: recessive run stuffed with dominant
        for (int i = 0; i < 5; i++) addVec(5, 1, 1, 1, 1, 1, 0, 0);
        addVec(5, 1, 0, 1, 0, 0, 1, 0);
        addVec(5, 1, 1, 1, 1, 1, 0, 0);
        addVec(5, 0, 0, 0, 0, 0, 0, 0);
        // Test 6: sample in ERROR together with destuff_en=0 is ignored, error clears
        for (int i = 0; i < 5; i++) addVec(6, 1, 1, 1, 1, 1, 0, 0);
        addVec(6, 1, 1, 1, 0, 0, 0, 1);
        addVec(6, 1, 0, 0, 0, 0, 0, 0);
        addVec(6, 1, 0, 1, 1, 0, 0, 0);
        addVec(6, 0, 0, 0, 0, 0, 0, 0);

        rst_n            = 1'b0;
        bus.rx           = 1'b1;
        bus.sample_point = 1'b0;
        bus.destuff_en   = 1'b0;
        bus.crc_en       = 1'b0;
        bus.crc_clr      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", 0, 0, 0, 0);
        checkValue("reset_crc", bus.crc_out, 15'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].sp, vecs[i].rx, vecs[i].den, 1'b0, 1'b0);
            checkOutput($sformatf("table_t%0d_v%0d", vecs[i].tag, i),
                        vecs[i].ev, vecs[i].ed, vecs[i].es, vecs[i].ee);
        end

        // CRC: clear, single 1 bit, no change without sample_point
        applyStimulus(0, 0, 0, 0, 1);
        checkValue("crc_clear", bus.crc_out, 15'h0000);
        applyStimulus(1, 1, 0, 1, 0);
        checkOutput("crc_single_bit", 1, 1, 0, 0);
        checkValue("crc_single", bus.crc_out, 15'h4599);
        checkValue("crc_zero_low", {14'd0, bus.crc_zero}, 15'd0);
        @(posedge clk);
        #1;
        checkOutput("no_sample_idle", 0, 0, 0, 0);
        checkValue("crc_hold_idle", bus.crc_out, 15'h4599);

        // crc_clr beats a coinciding update, but the bit is still delivered
        applyStimulus(1, 1, 0, 1, 1);
        checkOutput("clr_prio_bit", 1, 1, 0, 0);
        checkValue("clr_prio_crc", bus.crc_out, 15'h0000);
        checkValue("crc_zero_high", {14'd0, bus.crc_zero}, 15'd1);

        // 40-bit payload against software CRC, then append CRC for a zero remainder
        payload = 40'hC35A0F96E7;
        model   = 15'h0000;
        for (int i = 39; i >= 0; i--) begin
            applyStimulus(1, payload[i], 0, 1, 0);
            model = crc_step(model, payload[i]);
        end
        checkValue("crc_payload", bus.crc_out, model);
        for (int i = 14; i >= 0; i--) begin
            applyStimulus(1, model[i], 0, 1, 0);
        end
        checkValue("crc_residue", bus.crc_out, 15'h0000);
        checkValue("crc_zero_residue", {14'd0, bus.crc_zero}, 15'd1);

        // crc_en=0 leaves CRC untouched
        applyStimulus(1, 1, 0, 0, 0);
        checkValue("crc_en_off", bus.crc_out, 15'h0000);

        // Stuff bits are excluded from the CRC
        model = 15'h0000;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 1, 1, 0);
            model = crc_step(model, 1'b1);
        end
        applyStimulus(1, 0, 1, 1, 0);
        checkOutput("crc_stuff_pulse", 0, 0, 1, 0);
        checkValue("crc_skip_stuff", bus.crc_out, model);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset mid-frame in EXPECT_STUFF with nonzero CRC
        applyStimulus(1, 1, 0, 1, 1);
        applyStimulus(1, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 0, 0);
        checkOutput("pre_reset_valid", 1, 0, 0, 0);
        checkValue("pre_reset_crc", bus.crc_out, 15'h4599);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", 0, 0, 0, 0);
        checkValue("async_reset_crc", bus.crc_out, 15'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("post_reset_first", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 0, 0);
        checkOutput("post_reset_fifth", 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("post_reset_err", 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("post_reset_clear", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
